// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg: opcodes, format enum, type_flags bit indices and helpers for the RV32/RV64I encoder
package riscv_enc_pkg;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_REG_W  = 7'h3b;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int TF_R   = 0;
   localparam int TF_I   = 1;
   localparam int TF_L   = 2;
   localparam int TF_JR  = 3;
   localparam int TF_S   = 4;
   localparam int TF_SB  = 5;
   localparam int TF_AUI = 6;
   localparam int TF_LUI = 7;
   localparam int TF_J   = 8;
   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NOP} fmt_e;
   // true when v is representable as an n-bit two's-complement value
   function automatic logic fits_signed(input logic [31:0] v, input int n);
      logic [31:0] t;
      t = 32'($signed(v) >>> (n - 1));
      return (t == '0) || (t == '1);
   endfunction
endpackage

// File: rtl/imm_packer.sv
// imm_packer: scatters the immediate into its format's bit positions; range check under ENC_RANGE_CHECK_EN
module imm_packer
   import riscv_enc_pkg::*;
(
   input  fmt_e        i_fmt,
   input  logic [31:0] i_imm,
   output logic [31:0] o_skel,
   output logic        o_err
);
   // immediate bit placement per format; formats without an immediate contribute zeros
   always_comb begin
      o_skel = '0;
      case (i_fmt)
         FMT_I:   o_skel = {i_imm[11:0], 20'b0};
         FMT_S:   o_skel = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
         FMT_B:   o_skel = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
         FMT_U:   o_skel = {i_imm[31:12], 12'b0};
         FMT_J:   o_skel = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
         default: o_skel = '0;
      endcase
   end
`ifdef ENC_RANGE_CHECK_EN
   // flag immediates that do not survive truncation into the format's field
   always_comb begin
      o_err = 1'b0;
      case (i_fmt)
         FMT_I, FMT_S: o_err = !fits_signed(i_imm, 12);
         FMT_B:        o_err = i_imm[0] || !fits_signed(i_imm, 13);
         FMT_J:        o_err = i_imm[0] || !fits_signed(i_imm, 21);
         FMT_U:        o_err = |i_imm[11:0];
         default:      o_err = 1'b0;
      endcase
   end
`else
   assign o_err = 1'b0;
`endif
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32/RV64I instruction encoder with sequential byte address tag (option ENC_RANGE_CHECK_EN)
module instr_encoder
   import riscv_enc_pkg::*;
#(
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [8:0]        type_flags,
   input  logic              w_op,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err
);
   localparam logic [8:0] F_R   = 9'b1 << TF_R;
   localparam logic [8:0] F_I   = 9'b1 << TF_I;
   localparam logic [8:0] F_IL  = (9'b1 << TF_I) | (9'b1 << TF_L);
   localparam logic [8:0] F_IJR = (9'b1 << TF_I) | (9'b1 << TF_JR);
   localparam logic [8:0] F_S   = 9'b1 << TF_S;
   localparam logic [8:0] F_SB  = 9'b1 << TF_SB;
   localparam logic [8:0] F_AUI = 9'b1 << TF_AUI;
   localparam logic [8:0] F_LUI = 9'b1 << TF_LUI;
   localparam logic [8:0] F_J   = 9'b1 << TF_J;
   logic              w_en, w_hs, w_ill, w_rerr;
   fmt_e              w_fmt;
   logic [6:0]        w_opc;
   logic [31:0]       w_skel, w_fields, w_word;
   logic              r1_valid, r1_ill, r2_valid;
   fmt_e              r1_fmt;
   logic [6:0]        r1_op, r1_f7;
   logic [4:0]        r1_rd, r1_rs1, r1_rs2;
   logic [2:0]        r1_f3;
   logic [31:0]       r1_imm;
   logic [ADDR_W-1:0] r_cnt;
   assign w_en      = !r2_valid || out_ready;
   assign w_hs      = r2_valid && out_ready;
   assign in_ready  = w_en;
   assign out_valid = r2_valid;
   // classify the one-hot flag pattern into format and opcode; anything else is illegal
   always_comb begin
      w_fmt = FMT_NOP;
      w_opc = OP_IMM;
      w_ill = 1'b0;
      case (type_flags)
         F_R:     begin w_fmt = FMT_R; w_opc = w_op ? OP_REG_W : OP_REG; end
         F_I:     begin w_fmt = FMT_I; w_opc = OP_IMM;    end
         F_IL:    begin w_fmt = FMT_I; w_opc = OP_LOAD;   end
         F_IJR:   begin w_fmt = FMT_I; w_opc = OP_JALR;   end
         F_S:     begin w_fmt = FMT_S; w_opc = OP_STORE;  end
         F_SB:    begin w_fmt = FMT_B; w_opc = OP_BRANCH; end
         F_AUI:   begin w_fmt = FMT_U; w_opc = OP_AUIPC;  end
         F_LUI:   begin w_fmt = FMT_U; w_opc = OP_LUI;    end
         F_J:     begin w_fmt = FMT_J; w_opc = OP_JAL;    end
         default: w_ill = 1'b1;
      endcase
   end
   // stage 1: capture classification and raw fields
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid <= 1'b0;
      end else if (w_en) begin
         r1_valid <= in_valid;
         if (in_valid) begin
            r1_fmt <= w_fmt;
            r1_op  <= w_opc;
            r1_ill <= w_ill;
            r1_rd  <= rd;
            r1_rs1 <= rs1;
            r1_rs2 <= rs2;
            r1_f3  <= funct3;
            r1_f7  <= funct7;
            r1_imm <= imm;
         end
      end
   end
   imm_packer u_imm (
      .i_fmt  (r1_fmt),
      .i_imm  (r1_imm),
      .o_skel (w_skel),
      .o_err  (w_rerr)
   );
   assign w_fields = (r1_fmt == FMT_R) ? {r1_f7, r1_rs2, r1_rs1, r1_f3, r1_rd, r1_op} :
                     (r1_fmt == FMT_I) ? {12'b0, r1_rs1, r1_f3, r1_rd, r1_op} :
                     (r1_fmt == FMT_S || r1_fmt == FMT_B) ? {7'b0, r1_rs2, r1_rs1, r1_f3, 5'b0, r1_op} :
                     {20'b0, r1_rd, r1_op};
   assign w_word = (r1_fmt == FMT_NOP) ? NOP : (w_skel | w_fields);
   // stage 2: output register plus handshake-driven address counter; a word loaded during a handshake takes the next address
   always_ff @(posedge clk) begin
      if (rst) begin
         r2_valid  <= 1'b0;
         out_instr <= '0;
         out_err   <= 1'b0;
         out_addr  <= BASE_ADDR;
         r_cnt     <= BASE_ADDR;
      end else begin
         if (w_hs) r_cnt <= r_cnt + ADDR_W'(4);
         if (w_en) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
               out_instr <= w_word;
               out_err   <= r1_ill | w_rerr;
               out_addr  <= w_hs ? r_cnt + ADDR_W'(4) : r_cnt;
            end
         end
      end
   end
endmodule
